// File: rtl/mac_array_seq_if.sv
// Bus between the core FSM / array datapath (master side) and the tile
// sequencer (slave side). Clock and reset stay plain ports on the modules.
interface mac_array_seq_if #(
  parameter int addr_w = 11,
  parameter int col    = 8
);

  // Tile request from the core FSM
  logic              start;
  logic [addr_w-1:0] n_pix;
  logic [addr_w-1:0] k_base;
  logic [addr_w-1:0] a_base;

  // Bottom-row valid bits coming back from the array
  logic [col-1:0]    valid;

  // SRAM read ports and array instruction driven by the sequencer
  logic              k_rd;
  logic [addr_w-1:0] k_addr;
  logic              a_rd;
  logic [addr_w-1:0] a_addr;
  logic [1:0]        inst_w;

  // Tile status
  logic              busy;
  logic              done;
  logic [addr_w-1:0] out_cnt;

  modport master (
    output start, n_pix, k_base, a_base, valid,
    input  k_rd, k_addr, a_rd, a_addr, inst_w, busy, done, out_cnt
  );

  modport slave (
    input  start, n_pix, k_base, a_base, valid,
    output k_rd, k_addr, a_rd, a_addr, inst_w, busy, done, out_cnt
  );

endinterface

// File: rtl/mac_array_seq.sv
// Tile sequencer for the weight-stationary MAC array.
// One tile: load col kernel vectors, let them ripple through the array,
// stream n_pix activation vectors, then count result vectors leaving the
// bottom row and pulse done once all of them have been seen.
module mac_array_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 6
) (
  input logic           clk,
  input logic           reset,
  mac_array_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    K_DRAIN,
    EXEC,
    E_DRAIN,
    DONE
  } state_t;

  // Terminal values of the shared kernel-load / drain counter
  localparam logic [cnt_w-1:0]  load_last  = cnt_w'(col - 1);
  localparam logic [cnt_w-1:0]  drain_last = cnt_w'(row + col - 1);
  localparam logic [addr_w-1:0] one_a      = addr_w'(1);

  state_t            state;
  logic [cnt_w-1:0]  cnt;        // kernel index in LOAD_K, drain cycles in K_DRAIN
  logic [addr_w-1:0] pix_cnt;    // activation index in EXEC
  logic [addr_w-1:0] n_pix_q;
  logic [addr_w-1:0] a_base_q;

  logic              k_rd_q;
  logic [addr_w-1:0] k_addr_q;
  logic              a_rd_q;
  logic [addr_w-1:0] a_addr_q;
  logic [1:0]        inst_q;
  logic              busy_q;
  logic              done_q;
  logic [addr_w-1:0] out_cnt_q;

  logic              count_en;
  logic              res_valid;
  logic              unused_valid;

  // Only the last column's valid marks a complete result vector
  assign res_valid    = bus.valid[col-1];
  assign unused_valid = ^bus.valid[col-2:0];

  // Results are only meaningful while activations are in flight
  assign count_en = (state == EXEC) || (state == E_DRAIN);

  // Tile FSM with all outputs registered
  // NOTE: every register here uses <= so all of them update together from
  // the pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the
    // latched tile parameters, so an aborted tile leaves nothing behind.
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pix_cnt   <= '0;
      n_pix_q   <= '0;
      a_base_q  <= '0;
      k_rd_q    <= 1'b0;
      k_addr_q  <= '0;
      a_rd_q    <= 1'b0;
      a_addr_q  <= '0;
      inst_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      // Instruction trails the read enables by the SRAM read latency
      inst_q <= {a_rd_q, k_rd_q};

      // Saturating result counter; tile start below clears it
      if (count_en && res_valid && (out_cnt_q != n_pix_q)) begin
        out_cnt_q <= out_cnt_q + one_a;
      end

      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            n_pix_q   <= bus.n_pix;
            a_base_q  <= bus.a_base;
            out_cnt_q <= '0;
            cnt       <= '0;
            k_rd_q    <= 1'b1;
            k_addr_q  <= bus.k_base;
            busy_q    <= 1'b1;
            state     <= LOAD_K;
          end
        end

        LOAD_K: begin
          if (cnt == load_last) begin
            k_rd_q <= 1'b0;
            cnt    <= '0;
            state  <= K_DRAIN;
          end else begin
            cnt      <= cnt + cnt_w'(1);
            k_addr_q <= k_addr_q + one_a;
          end
        end

        K_DRAIN: begin
          if (cnt == drain_last) begin
            if (n_pix_q != '0) begin
              a_rd_q   <= 1'b1;
              a_addr_q <= a_base_q;
              pix_cnt  <= '0;
              state    <= EXEC;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end

        EXEC: begin
          // Address arithmetic wraps naturally at 2^addr_w
          if (pix_cnt == (n_pix_q - one_a)) begin
            a_rd_q <= 1'b0;
            state  <= E_DRAIN;
          end else begin
            pix_cnt  <= pix_cnt + one_a;
            a_addr_q <= a_addr_q + one_a;
          end
        end

        E_DRAIN: begin
          // No timeout: waits for every result vector of the tile
          if (out_cnt_q == n_pix_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.k_rd    = k_rd_q;
  assign bus.k_addr  = k_addr_q;
  assign bus.a_rd    = a_rd_q;
  assign bus.a_addr  = a_addr_q;
  assign bus.inst_w  = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.out_cnt = out_cnt_q;

  // Kernel and activation reads belong to different phases and never overlap
  assert property (@(posedge clk) disable iff (!reset) !(k_rd_q && a_rd_q));

  // The completion pulse is never issued while the tile still reports busy
  assert property (@(posedge clk) disable iff (!reset) done_q |-> !busy_q);

endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq: stimulus pushes the expected SRAM reads,
// instructions and completions (with their cycle numbers) into queues;
// a monitor pops and compares whenever the DUT presents one of them.
module tb_mac_array_seq;

  localparam int row    = 8;
  localparam int col    = 8;
  localparam int addr_w = 11;
  localparam int cnt_w  = 6;
  localparam int amod   = 1 << addr_w;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mac_array_seq_if #(.addr_w(addr_w), .col(col)) bus ();

  mac_array_seq #(
    .row(row), .col(col), .addr_w(addr_w), .cnt_w(cnt_w)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int cyc;   // cycle the event must appear in; -1 means any cycle
    int val;
  } exp_t;

  exp_t k_q[$];
  exp_t a_q[$];
  exp_t i_q[$];
  exp_t d_q[$];

  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   cyc        = 0;
  int   done_count = 0;
  int   lat        = 3;
  logic extra      = 1'b0;
  logic [7:0] pipe = '0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: every execute instruction produces one bottom-row result
  // lat cycles later; extra injects stray valid pulses.
  always @(negedge clk) begin
    if (!reset) pipe = '0;
    else        pipe = {pipe[6:0], (bus.inst_w == 2'b10)};
    bus.valid = {pipe[lat-1] | extra, 7'($urandom)};
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.k_rd) begin
      if (k_q.size() == 0) check("k_rd_spurious", bus.k_rd, 0);
      else begin
        e = k_q.pop_front();
        check("k_addr", bus.k_addr, e.val);
        check("k_cycle", cyc, e.cyc);
      end
    end
    if (bus.a_rd) begin
      if (a_q.size() == 0) check("a_rd_spurious", bus.a_rd, 0);
      else begin
        e = a_q.pop_front();
        check("a_addr", bus.a_addr, e.val);
        check("a_cycle", cyc, e.cyc);
      end
    end
    if (bus.inst_w != 2'b00) begin
      if (i_q.size() == 0) check("inst_spurious", bus.inst_w, 0);
      else begin
        e = i_q.pop_front();
        check("inst_w", bus.inst_w, e.val);
        check("inst_cycle", cyc, e.cyc);
      end
    end
    if (bus.done) begin
      done_count++;
      if (d_q.size() == 0) check("done_spurious", bus.done, 0);
      else begin
        e = d_q.pop_front();
        check("done_out_cnt", bus.out_cnt, e.val);
        check("done_busy", bus.busy, 0);
        if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a tile and queue the reads, instructions and completion it implies
  task automatic run_tile(input int kb, input int ab, input int n);
    int s;
    int first_a;
    bus.k_base = addr_w'(kb);
    bus.a_base = addr_w'(ab);
    bus.n_pix  = addr_w'(n);
    bus.start  = 1'b1;
    s = cyc;
    for (int i = 0; i < col; i++) begin
      k_q.push_back('{s + 1 + i, (kb + i) % amod});
      i_q.push_back('{s + 2 + i, 1});
    end
    first_a = s + 1 + col + (row + col);
    for (int j = 0; j < n; j++) begin
      a_q.push_back('{first_a + j, (ab + j) % amod});
      i_q.push_back('{first_a + 1 + j, 2});
    end
    d_q.push_back('{(n == 0) ? first_a : -1, n});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  // Bounded wait for one completion, then confirm it was the only one
  task automatic wait_done(input int exp_cnt, input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_count > d0) break;
    end
    check("done_seen", done_count, d0 + 1);
    idle(5);
    check("done_once", done_count - d0, 1);
    check("busy_after_done", bus.busy, 0);
    check("out_cnt_hold", bus.out_cnt, exp_cnt);
  endtask

  task automatic wait_a_rd(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.a_rd) break;
      @(posedge clk);
      #1;
    end
    check("a_rd_reached", bus.a_rd, 1);
  endtask

  initial begin
    int   n;
    logic hit;

    bus.start  = 1'b0;
    bus.n_pix  = '0;
    bus.k_base = '0;
    bus.a_base = '0;

    // Reset state
    reset = 1'b0;
    idle(2);
    check("rst_k_rd", bus.k_rd, 0);
    check("rst_a_rd", bus.a_rd, 0);
    check("rst_inst_w", bus.inst_w, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_out_cnt", bus.out_cnt, 0);
    reset = 1'b1;
    idle(2);

    // Nominal tile
    run_tile(0, 16, 36);
    wait_done(36, 200);

    // Empty tile: kernel load and drain only
    run_tile(40, 0, 0);
    wait_done(0, 100);

    // Second start during EXEC is ignored
    run_tile(100, 300, 20);
    wait_a_rd(100);
    bus.k_base = 11'd7;
    bus.a_base = 11'd900;
    bus.n_pix  = 11'd5;
    bus.start  = 1'b1;
    idle(1);
    bus.start  = 1'b0;
    wait_done(20, 200);

    // Activation address wrap
    run_tile(5, 2046, 4);
    wait_done(4, 100);

    // Stray valids in IDLE and K_DRAIN are ignored; extras saturate
    extra = 1'b1;
    idle(1);
    extra = 1'b0;
    idle(2);
    check("idle_valid_ignored", bus.out_cnt, 4);
    run_tile(64, 500, 3);
    idle(11);
    extra = 1'b1;
    idle(1);
    extra = 1'b0;
    idle(2);
    check("kdrain_valid_ignored", bus.out_cnt, 0);
    wait_a_rd(100);
    extra = 1'b1;
    idle(2);
    extra = 1'b0;
    wait_done(3, 100);

    // Reset in the middle of EXEC
    run_tile(8, 100, 20);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      hit = bus.a_rd && (bus.a_addr == 11'd110);
      if (hit) break;
    end
    check("pix10_reached", hit, 1);
    reset = 1'b0;
    k_q.delete();
    a_q.delete();
    i_q.delete();
    d_q.delete();
    n = done_count;
    @(negedge clk);
    check("midrst_k_rd", bus.k_rd, 0);
    check("midrst_a_rd", bus.a_rd, 0);
    check("midrst_a_addr", bus.a_addr, 0);
    check("midrst_k_addr", bus.k_addr, 0);
    check("midrst_inst_w", bus.inst_w, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_cnt", bus.out_cnt, 0);
    #1;
    reset = 1'b1;
    idle(lat + 6);
    check("midrst_no_done", done_count, n);
    run_tile(16, 200, 12);
    wait_done(12, 150);

    // Randomized tiles with varying array latency
    for (int t = 0; t < 6; t++) begin
      lat = $urandom_range(1, 6);
      n   = $urandom_range(1, 40);
      run_tile($urandom_range(0, amod - 1), $urandom_range(0, amod - 1), n);
      wait_done(n, 2 * col + row + n + 60);
      idle(8);
    end

    check("k_q_left", k_q.size(), 0);
    check("a_q_left", a_q.size(), 0);
    check("i_q_left", i_q.size(), 0);
    check("d_q_left", d_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
